// File: rtl/fe_fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fe_fetch_sequencer_pkg                                          |
// | Purpose  : Shared widths, defaults and FSM encoding for the fetch sequencer |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fe_fetch_sequencer_pkg;

    localparam int unsigned FE_DBITS    = 32;
    localparam int unsigned FE_INSTBITS = 32;
    localparam int unsigned FE_SQBITS   = 16;

    localparam logic [31:0] FE_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] FE_NOP_INST = 32'h0000_0013;

    // Redirect bus {br_cond, pctarget} and FE latch {valid, inst, pc, pcplus, count}
    localparam int unsigned FROM_AGEX_TO_FE_WIDTH = 1 + FE_DBITS;
    localparam int unsigned FE_LATCH_WIDTH        = 1 + FE_INSTBITS + (3 * FE_DBITS);

    localparam int unsigned        FE_ST_W    = 1;
    localparam logic [FE_ST_W-1:0] FE_ST_RUN  = 1'b0;
    localparam logic [FE_ST_W-1:0] FE_ST_HOLD = 1'b1;

endpackage : fe_fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fe_fetch_sequencer_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fe_skid_buffer                                                  |
// | Purpose  : One-entry {pc, inst, valid} holding slot for a stalled fetch     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fe_skid_buffer
    import fe_fetch_sequencer_pkg::*;
#(
    parameter int unsigned DBITS    = FE_DBITS,
    parameter int unsigned INSTBITS = FE_INSTBITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                unload_i,
    input  logic                clear_i,
    input  logic [DBITS-1:0]    pc_i,
    input  logic [INSTBITS-1:0] inst_i,
    output logic                valid_o,
    output logic [DBITS-1:0]    pc_o,
    output logic [INSTBITS-1:0] inst_o
);

    logic                valid_q, valid_d;
    logic [DBITS-1:0]    pc_q,    pc_d;
    logic [INSTBITS-1:0] inst_q,  inst_d;

    // Clear and unload win over load; payload is only captured on load
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i || unload_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule : fe_skid_buffer
`default_nettype wire

// File: rtl/fe_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fe_fetch_sequencer                                              |
// | Purpose  : PC owner, imem driver and FE latch with stall skid and redirect  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fe_fetch_sequencer
    import fe_fetch_sequencer_pkg::*;
#(
    parameter int unsigned         DBITS    = FE_DBITS,
    parameter int unsigned         INSTBITS = FE_INSTBITS,
    parameter logic [DBITS-1:0]    RESET_PC = FE_RESET_PC,
    parameter logic [INSTBITS-1:0] NOP_INST = FE_NOP_INST,
    parameter int unsigned         SQBITS   = FE_SQBITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                agex_br_cond,
    input  logic [DBITS-1:0]    agex_pctarget,
    input  logic                de_stall,
    output logic [DBITS-1:0]    imem_addr,
    input  logic [INSTBITS-1:0] imem_rdata,
    output logic                fe_valid,
    output logic [INSTBITS-1:0] fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic [DBITS-1:0]    fe_inst_count,
    output logic [SQBITS-1:0]   squash_count
);

    localparam logic [DBITS-1:0] c_PC_STEP = DBITS'(4);

    logic [FE_ST_W-1:0]  state_q, state_d;
    logic [DBITS-1:0]    pc_q, pc_d;
    logic [DBITS-1:0]    req_pc_q, req_pc_d;
    logic                req_valid_q, req_valid_d;
    logic                fe_valid_q, fe_valid_d;
    logic [INSTBITS-1:0] fe_inst_q, fe_inst_d;
    logic [DBITS-1:0]    fe_pc_q, fe_pc_d;
    logic [DBITS-1:0]    inst_count_q, inst_count_d;
    logic [SQBITS-1:0]   squash_q, squash_d;

    logic w_pc_inc, w_req_issue, w_req_drop;
    logic w_fe_from_mem, w_fe_from_skid, w_flush;
    logic w_skid_load, w_skid_unload, w_skid_clear;
    logic w_fe_load_valid;

    logic                w_skid_valid;
    logic [DBITS-1:0]    w_skid_pc;
    logic [INSTBITS-1:0] w_skid_inst;

    logic [1:0]          w_sq_inc;
    logic [SQBITS:0]     w_sq_sum;
    logic                w_unused_tgt_lsbs;

    assign w_unused_tgt_lsbs = ^agex_pctarget[1:0];

    fe_skid_buffer #(
        .DBITS    (DBITS),
        .INSTBITS (INSTBITS)
    ) u_skid (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (w_skid_load),
        .unload_i (w_skid_unload),
        .clear_i  (w_skid_clear),
        .pc_i     (req_pc_q),
        .inst_i   (imem_rdata),
        .valid_o  (w_skid_valid),
        .pc_o     (w_skid_pc),
        .inst_o   (w_skid_inst)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FE_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (agex_br_cond) begin
            state_d = FE_ST_RUN;
        end else begin
            case (state_q)
                FE_ST_RUN:  if (de_stall && req_valid_q) state_d = FE_ST_HOLD;
                FE_ST_HOLD: if (!de_stall)               state_d = FE_ST_RUN;
                default:                                 state_d = FE_ST_RUN;
            endcase
        end
    end

    // ---------------- FSM: control outputs ----------------
    // Redirect beats stall beats advance.
    always_comb begin
        w_pc_inc       = 1'b0;
        w_req_issue    = 1'b0;
        w_req_drop     = 1'b0;
        w_fe_from_mem  = 1'b0;
        w_fe_from_skid = 1'b0;
        w_flush        = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_unload  = 1'b0;
        w_skid_clear   = 1'b0;
        if (agex_br_cond) begin
            w_flush      = 1'b1;
            w_req_drop   = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (state_q)
                FE_ST_RUN: begin
                    if (!de_stall) begin
                        w_fe_from_mem = 1'b1;
                        w_pc_inc      = 1'b1;
                        w_req_issue   = 1'b1;
                    end else if (req_valid_q) begin
                        // Park the returning word; pc_q is re-presented while parked
                        w_skid_load = 1'b1;
                        w_req_drop  = 1'b1;
                    end
                end
                FE_ST_HOLD: begin
                    if (!de_stall) begin
                        w_fe_from_skid = 1'b1;
                        w_skid_unload  = 1'b1;
                        w_pc_inc       = 1'b1;
                        w_req_issue    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pc_d = pc_q;
        if (agex_br_cond) begin
            pc_d = {agex_pctarget[DBITS-1:2], 2'b00};
        end else if (w_pc_inc) begin
            pc_d = pc_q + c_PC_STEP;
        end

        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        if (w_req_issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
        end else if (w_req_drop) begin
            req_valid_d = 1'b0;
        end
    end

    // Invalid latch contents are always padded to NOP / zero PC
    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_inst_d  = fe_inst_q;
        fe_pc_d    = fe_pc_q;
        if (w_flush) begin
            fe_valid_d = 1'b0;
            fe_inst_d  = NOP_INST;
            fe_pc_d    = '0;
        end else if (w_fe_from_mem) begin
            fe_valid_d = req_valid_q;
            fe_inst_d  = req_valid_q ? imem_rdata : NOP_INST;
            fe_pc_d    = req_valid_q ? req_pc_q   : '0;
        end else if (w_fe_from_skid) begin
            fe_valid_d = 1'b1;
            fe_inst_d  = w_skid_inst;
            fe_pc_d    = w_skid_pc;
        end
    end

    assign w_fe_load_valid = (w_fe_from_mem && req_valid_q) || w_fe_from_skid;
    assign inst_count_d    = inst_count_q + {{(DBITS-1){1'b0}}, w_fe_load_valid};

    // One extra carry bit detects overflow; SQBITS must be at least 2
    assign w_sq_inc = {1'b0, fe_valid_q} + {1'b0, req_valid_q} + {1'b0, w_skid_valid};
    assign w_sq_sum = {1'b0, squash_q} + {{(SQBITS-1){1'b0}}, w_sq_inc};

    always_comb begin
        squash_d = squash_q;
        if (agex_br_cond) begin
            squash_d = w_sq_sum[SQBITS] ? '1 : w_sq_sum[SQBITS-1:0];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            req_valid_q  <= 1'b0;
            fe_valid_q   <= 1'b0;
            fe_inst_q    <= NOP_INST;
            fe_pc_q      <= '0;
            inst_count_q <= '0;
            squash_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            fe_valid_q   <= fe_valid_d;
            fe_inst_q    <= fe_inst_d;
            fe_pc_q      <= fe_pc_d;
            inst_count_q <= inst_count_d;
            squash_q     <= squash_d;
        end
    end

    assign imem_addr     = {pc_q[DBITS-1:2], 2'b00};
    assign fe_valid      = fe_valid_q;
    assign fe_inst       = fe_inst_q;
    assign fe_pc         = fe_pc_q;
    assign fe_pcplus     = fe_valid_q ? (fe_pc_q + c_PC_STEP) : '0;
    assign fe_inst_count = inst_count_q;
    assign squash_count  = squash_q;

endmodule : fe_fetch_sequencer
`default_nettype wire
